// File: rtl/countdown_timer_if.sv
// ============================================================================
// countdown_timer_if : keypad/command inputs and M:SS display outputs. Rev 1.0
// ============================================================================
`default_nettype none

interface countdown_timer_if;
   logic [3:0] digit;
   logic       digit_valid;
   logic       start;
   logic       stop;
   logic       clear;
   logic       door_closed;
   logic [3:0] minutes;
   logic [3:0] ten_secs;
   logic [3:0] unit_secs;
   logic       running;
   logic       done;

   modport master (
      output digit, digit_valid, start, stop, clear, door_closed,
      input  minutes, ten_secs, unit_secs, running, done
   );

   modport slave (
      input  digit, digit_valid, start, stop, clear, door_closed,
      output minutes, ten_secs, unit_secs, running, done
   );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// ============================================================================
// countdown_timer : microwave M:SS keypad entry and 1 Hz countdown core. Rev 1.0
// ============================================================================
`default_nettype none

module countdown_timer #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   countdown_timer_if.slave tmr
);

   localparam int            PW        = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RUNNING = 2'd1;
   localparam logic [1:0] S_PAUSED  = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [3:0]    min_q, min_d;
   logic [3:0]    ten_q, ten_d;
   logic [3:0]    unit_q, unit_d;
   logic [PW-1:0] presc_q, presc_d;

   logic [3:0]    dec_min, dec_ten, dec_unit;
   logic          time_zero;
   logic          last_sec;
   logic          digit_ok;
   logic          pause_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         min_q   <= 4'd0;
         ten_q   <= 4'd0;
         unit_q  <= 4'd0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         ten_q   <= ten_d;
         unit_q  <= unit_d;
         presc_q <= presc_d;
      end
   end

   // One-second borrow chain; minutes never underflow since RUNNING implies non-zero time.
   always_comb begin
      dec_min  = min_q;
      dec_ten  = ten_q;
      dec_unit = unit_q;
      if (unit_q != 4'd0) begin
         dec_unit = unit_q - 4'd1;
      end else begin
         dec_unit = 4'd9;
         if (ten_q != 4'd0) begin
            dec_ten = ten_q - 4'd1;
         end else begin
            dec_ten = 4'd5;
            dec_min = min_q - 4'd1;
         end
      end
   end

   always_comb begin
      time_zero = (min_q == 4'd0) && (ten_q == 4'd0) && (unit_q == 4'd0);
      last_sec  = (min_q == 4'd0) && (ten_q == 4'd0) && (unit_q == 4'd1);
      // unit_secs moves into the tens slot, so it must already be a valid tens digit.
      digit_ok  = (tmr.digit <= 4'd9) && (unit_q <= 4'd5);
      pause_req = tmr.stop || !tmr.door_closed;
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      ten_d   = ten_q;
      unit_d  = unit_q;
      presc_d = presc_q;

      if (tmr.clear) begin
         state_d = S_IDLE;
         min_d   = 4'd0;
         ten_d   = 4'd0;
         unit_d  = 4'd0;
         presc_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (tmr.start && tmr.door_closed && !time_zero) begin
                  state_d = S_RUNNING;
                  presc_d = '0;
               end else if (tmr.digit_valid && digit_ok) begin
                  min_d  = ten_q;
                  ten_d  = unit_q;
                  unit_d = tmr.digit;
               end
            end
            S_RUNNING: begin
               if (pause_req) begin
                  state_d = S_PAUSED;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  min_d   = dec_min;
                  ten_d   = dec_ten;
                  unit_d  = dec_unit;
                  if (last_sec) begin
                     state_d = S_DONE;
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            S_PAUSED: begin
               if (tmr.stop) begin
                  state_d = S_IDLE;
                  min_d   = 4'd0;
                  ten_d   = 4'd0;
                  unit_d  = 4'd0;
                  presc_d = '0;
               end else if (tmr.start && tmr.door_closed) begin
                  state_d = S_RUNNING;
               end
            end
            S_DONE: begin
               if (tmr.start || tmr.stop || tmr.digit_valid) begin
                  state_d = S_IDLE;
                  presc_d = '0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      tmr.minutes   = min_q;
      tmr.ten_secs  = ten_q;
      tmr.unit_secs = unit_q;
      tmr.running   = (state_q == S_RUNNING);
      tmr.done      = (state_q == S_DONE);
   end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
// tb_countdown_timer : random + directed scoreboard bench for countdown_timer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_countdown_timer;

   localparam int TPS = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   bit   door;

   int n_checks = 0;
   int n_pass   = 0;

   int m_mode;
   int m_secs;
   int m_phase;

   logic [13:0] exp_q[$];

   countdown_timer_if tif ();

   countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .tmr   (tif)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] got_vec();
      return {tif.minutes, tif.ten_secs, tif.unit_secs, tif.running, tif.done};
   endfunction

   function automatic logic [13:0] model_vec();
      logic [3:0] mm, ts, us;
      mm = 4'(m_secs / 60);
      ts = 4'((m_secs % 60) / 10);
      us = 4'(m_secs % 10);
      return {mm, ts, us, m_mode == M_RUN, m_mode == M_DONE};
   endfunction

   task automatic check(input string name, input logic [13:0] g, input logic [13:0] e);
      n_checks++;
      if (g === e) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got %0d:%0d%0d running=%b done=%b, expected %0d:%0d%0d running=%b done=%b",
                  name, $time, g[13:10], g[9:6], g[5:2], g[1], g[0],
                  e[13:10], e[9:6], e[5:2], e[1], e[0]);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_secs  = 0;
      m_phase = 0;
   endtask

   // Reference keeps time as total seconds; keypad entry works on the decimal MSS number.
   task automatic model_step(input bit dv, input int d, input bit st, input bit sp,
                             input bit clr, input bit dr);
      int cur;
      int nd;
      if (clr) begin
         model_reset();
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (st && dr && m_secs > 0) begin
                  m_mode  = M_RUN;
                  m_phase = 0;
               end else if (dv) begin
                  cur = (m_secs / 60) * 100 + (m_secs % 60);
                  if (d <= 9 && (cur % 10) <= 5) begin
                     nd     = (cur * 10 + d) % 1000;
                     m_secs = (nd / 100) * 60 + (nd % 100);
                  end
               end
            end
            M_RUN: begin
               if (sp || !dr) begin
                  m_mode = M_PAUSE;
               end else begin
                  m_phase++;
                  if (m_phase == TPS) begin
                     m_phase = 0;
                     m_secs--;
                     if (m_secs == 0) m_mode = M_DONE;
                  end
               end
            end
            M_PAUSE: begin
               if (sp) model_reset();
               else if (st && dr) m_mode = M_RUN;
            end
            default: begin
               if (st || sp || dv) begin
                  m_mode  = M_IDLE;
                  m_phase = 0;
               end
            end
         endcase
      end
   endtask

   task automatic step(input bit dv, input int d, input bit st, input bit sp, input bit clr);
      tif.digit_valid = dv;
      tif.digit       = 4'(d);
      tif.start       = st;
      tif.stop        = sp;
      tif.clear       = clr;
      tif.door_closed = door;
      @(posedge clk);
      #1;
      model_step(dv, d, st, sp, clr, door);
      exp_q.push_back(model_vec());
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 0, 0);
   endtask

   task automatic key(input int d);
      step(1, d, 0, 0, 0);
   endtask

   always @(negedge clk) begin : monitor
      logic [13:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cycle", got_vec(), e);
      end
   end

   initial begin
      door            = 1'b1;
      tif.digit_valid = 1'b0;
      tif.digit       = 4'd0;
      tif.start       = 1'b0;
      tif.stop        = 1'b0;
      tif.clear       = 1'b0;
      tif.door_closed = 1'b1;
      model_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_state", got_vec(), 14'd0);
      rst_n = 1'b1;

      // Entry and leading-digit discard
      key(1); key(3); key(0); key(7);

      // Rejects and door interlock on start
      step(0, 0, 0, 0, 1);
      key(1); key(9); key(0); key(12);
      door = 1'b0;
      step(0, 0, 1, 0, 0);
      door = 1'b1;
      idle(1);

      // Borrow chain from 1:00
      step(0, 0, 0, 0, 1);
      key(1); key(0); key(0);
      step(0, 0, 1, 0, 0);
      idle(10);

      // Completion and DONE consuming the digit
      step(0, 0, 0, 0, 1);
      key(2);
      step(0, 0, 1, 0, 0);
      idle(9);
      key(5);
      idle(2);

      // Pause on door open, resume, double stop
      step(0, 0, 0, 0, 1);
      key(1); key(0);
      step(0, 0, 1, 0, 0);
      idle(6);
      door = 1'b0;
      idle(3);
      door = 1'b1;
      step(0, 0, 1, 0, 0);
      idle(6);
      step(0, 0, 0, 1, 0);
      idle(1);
      step(0, 0, 0, 1, 0);
      idle(2);

      // clear beats start while paused
      key(5);
      step(0, 0, 1, 0, 0);
      idle(2);
      step(0, 0, 0, 1, 0);
      step(0, 0, 1, 0, 1);
      idle(2);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 63);
         if ($urandom_range(0, 15) == 0) door = ~door;
         if (r < 8 && door)  key($urandom_range(0, 15));
         else if (r < 13)    step(0, 0, 1, 0, 0);
         else if (r == 13)   step(0, 0, 0, 1, 0);
         else if (r == 14)   step(0, 0, 0, 0, 1);
         else                idle(1);
      end

      // Asynchronous reset mid-count
      door = 1'b1;
      step(0, 0, 0, 0, 1);
      key(3); key(0);
      step(0, 0, 1, 0, 0);
      idle(5);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset", got_vec(), 14'd0);
      #2;
      rst_n = 1'b1;
      model_reset();
      key(4);
      idle(2);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
